// File: rtl/inst_queue.sv
// Instruction queue: circular FIFO of {inst, pc} between fetch and dispatch.
// Optional same-cycle bypass of an empty queue is enabled by defining IQ_BYPASS_EN.
module inst_queue #(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [63:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic w_active;
    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_byp_take;
    logic w_push;
    logic w_pop;

    assign w_active = rdy_in & ~flush_in;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_FULL);

`ifdef IQ_BYPASS_EN
    assign w_byp = w_active & w_empty & in_valid;
`else
    assign w_byp = 1'b0;
`endif
    // A bypassed instruction consumed in the same cycle never touches the array.
    assign w_byp_take = w_byp & out_ready;

    assign in_ready  = w_active & ~w_full;
    assign out_valid = (w_active & ~w_empty) | w_byp;

    assign w_push = in_valid & in_ready & ~w_byp_take;
    assign w_pop  = out_valid & out_ready & ~w_empty;

    always_comb begin
        out_inst = 32'h0;
        out_pc   = 32'h0;
        if (w_byp) begin
            out_inst = in_inst;
            out_pc   = in_pc;
        end else if (out_valid) begin
            out_inst = r_mem[r_head][63:32];
            out_pc   = r_mem[r_head][31:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush_in)) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_tail] <= {in_inst, in_pc};
    end

    assign count = r_count;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue; a negedge monitor checks dispatched entries
// against a scoreboard filled by the stimulus process.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush_in, in_valid, out_ready;
    logic [31:0]      in_inst, in_pc;
    logic             in_ready, out_valid;
    logic [31:0]      out_inst, out_pc;
    logic [PTR_W:0]   count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] sb [$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush_in = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic rd);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = rd;
        sb.push_back({inst, pc});
    endtask

    // Monitor: every handshake-completed dispatch must match the oldest expectation.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop_pc", out_pc, 32'hdead_beef);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    check("pop_inst", out_inst, e[63:32]);
                    check("pop_pc", out_pc, e[31:0]);
                end
            end else if (!out_valid) begin
                check("idle_zero", out_inst | out_pc, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); rst_in = 1'b1; in_inst = '0; in_pc = '0;
        step(); step();
        rst_in = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);

        // Single push, one-cycle latency
        push(32'h00500093, 32'h0, 1'b0);
        step(); idle();
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_inst", out_inst, 32'h00500093);
        check("t1_out_pc", out_pc, 32'h0);
        check("t1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step(); idle();
        check("t1_drained", 32'(count), 32'd0);

        // Fill to DEPTH, refused extra push (also while popping), drain in order
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h1000_0000 + 32'(i), 32'h100 + 32'(4*i), 1'b0);
            step();
        end
        idle();
        check("t2_full_count", 32'(count), 32'(DEPTH));
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_inst = 32'h1111_1111; in_pc = 32'h900;
        #1 check("t2_17th_refused", 32'(in_ready), 32'd0);
        step();
        check("t2_17th_count", 32'(count), 32'(DEPTH));
        out_ready = 1'b1;
        #1 check("t2_full_pop_refuse", 32'(in_ready), 32'd0);
        step();
        check("t2_after_pop", 32'(count), 32'(DEPTH-1));
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH-1; i++) step();
        idle();
        check("t2_empty", 32'(count), 32'd0);

        // Steady stream with wrap-around
        push(32'h2000_0000, 32'h0, 1'b0);
        step();
        for (int i = 1; i <= 40; i++) begin
            push(32'h2000_0000 + 32'(i), 32'(4*i), 1'b1);
            #1;
            if (i == 1 || i == 20 || i == 40) begin
                check("t3_in_ready", 32'(in_ready), 32'd1);
                check("t3_out_valid", 32'(out_valid), 32'd1);
            end
            step();
            check("t3_count", 32'(count), 32'd1);
        end
        idle(); out_ready = 1'b1;
        step(); idle();
        check("t3_drained", 32'(count), 32'd0);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 5; i++) begin
            push(32'h3000_0000 + 32'(i), 32'h300 + 32'(4*i), 1'b0);
            step();
        end
        idle();
        check("t4_count5", 32'(count), 32'd5);
        flush_in = 1'b1; in_valid = 1'b1; in_inst = 32'h3333_3333; in_pc = 32'h3fc; out_ready = 1'b1;
        #1;
        check("t4_flush_in_ready", 32'(in_ready), 32'd0);
        check("t4_flush_out_valid", 32'(out_valid), 32'd0);
        step();
        sb.delete();
        idle(); out_ready = 1'b1;
        check("t4_post_count", 32'(count), 32'd0);
        check("t4_post_valid", 32'(out_valid), 32'd0);
        step(); step(); idle();

        // rdy_in low freezes everything
        for (int i = 0; i < 3; i++) begin
            push(32'h4000_0000 + 32'(i), 32'h400 + 32'(4*i), 1'b0);
            step();
        end
        idle();
        rdy_in = 1'b0; in_valid = 1'b1; in_inst = 32'h4444_4444; in_pc = 32'h4fc; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_in_ready", 32'(in_ready), 32'd0);
            check("t5_out_valid", 32'(out_valid), 32'd0);
            step();
            check("t5_count", 32'(count), 32'd3);
        end
        idle(); out_ready = 1'b1;
        step(); step(); step(); idle();
        check("t5_drained", 32'(count), 32'd0);

        // Empty queue with in_valid and out_ready both high
        push(32'h00a00113, 32'h500, 1'b1);
        #1;
`ifdef IQ_BYPASS_EN
        check("t6_byp_valid", 32'(out_valid), 32'd1);
        check("t6_byp_inst", out_inst, 32'h00a00113);
        step(); idle();
        check("t6_byp_count", 32'(count), 32'd0);
`else
        check("t6_nobyp_valid", 32'(out_valid), 32'd0);
        step(); idle(); out_ready = 1'b1;
        check("t6_next_valid", 32'(out_valid), 32'd1);
        check("t6_next_inst", out_inst, 32'h00a00113);
        step(); idle();
        check("t6_count", 32'(count), 32'd0);
`endif

        // Reset mid-operation discards entries
        push(32'h5000_0000, 32'h600, 1'b0); step();
        push(32'h5000_0001, 32'h604, 1'b0); step();
        idle();
        check("t7_count2", 32'(count), 32'd2);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        sb.delete();
        #1;
        check("t7_rst_count", 32'(count), 32'd0);
        check("t7_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step(); step(); idle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
